// File: rtl/dcache_pkg.sv
// Shared types, geometry and line helpers for the direct-mapped write-back data cache controller.
package dcache_pkg;

  localparam int unsigned ADDR_WIDTH  = 32;
  localparam int unsigned INDEX_WIDTH = 8;
  localparam int unsigned LINE_WIDTH  = 128;
  localparam int unsigned WORD_WIDTH  = 32;
  localparam int unsigned OFF_W       = $clog2(LINE_WIDTH / 8);
  localparam int unsigned TAG_W       = ADDR_WIDTH - INDEX_WIDTH - OFF_W;
  localparam int unsigned WSEL_W      = OFF_W - 2;
  localparam int unsigned STRB_W      = WORD_WIDTH / 8;
  localparam int unsigned LINES       = 1 << INDEX_WIDTH;

  typedef enum logic [1:0] {IDLE, LOOKUP, WRITEBACK, REFILL} state_t;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } tag_entry_t;

  typedef struct packed {
    logic                  op;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WORD_WIDTH-1:0] wdata;
    logic [STRB_W-1:0]     wstrb;
  } cpu_req_t;

  // Word 0 is the least significant word of the line.
  function automatic logic [WORD_WIDTH-1:0] word_sel(input logic [LINE_WIDTH-1:0] line,
                                                     input logic [WSEL_W-1:0]     sel);
    return line[32'(sel) * WORD_WIDTH +: WORD_WIDTH];
  endfunction

  function automatic logic [LINE_WIDTH-1:0] byte_merge(input logic [LINE_WIDTH-1:0] line,
                                                       input logic [WSEL_W-1:0]     sel,
                                                       input logic [WORD_WIDTH-1:0] wdata,
                                                       input logic [STRB_W-1:0]     wstrb);
    logic [LINE_WIDTH-1:0] res;
    res = line;
    for (int unsigned b = 0; b < STRB_W; b++) begin
      if (wstrb[b]) res[32'(sel) * WORD_WIDTH + b * 8 +: 8] = wdata[b * 8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dcache_if.sv
// CPU, line data memory and next-level memory signal bundle of the data cache controller.
interface dcache_if;
  import dcache_pkg::*;

  logic                   cpu_valid;
  logic                   cpu_op;
  logic [ADDR_WIDTH-1:0]  cpu_addr;
  logic [WORD_WIDTH-1:0]  cpu_wdata;
  logic [STRB_W-1:0]      cpu_wstrb;
  logic                   cpu_ready;
  logic [WORD_WIDTH-1:0]  cpu_rdata;

  logic                   dm_we;
  logic [INDEX_WIDTH-1:0] dm_rindex;
  logic [INDEX_WIDTH-1:0] dm_windex;
  logic [LINE_WIDTH-1:0]  dm_wdata;
  logic [LINE_WIDTH-1:0]  dm_rdata;

  logic                   mem_req;
  logic                   mem_we;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic [LINE_WIDTH-1:0]  mem_wdata;
  logic                   mem_ack;
  logic [LINE_WIDTH-1:0]  mem_rdata;

  modport master (
    input  cpu_valid, cpu_op, cpu_addr, cpu_wdata, cpu_wstrb,
    output cpu_ready, cpu_rdata,
    output dm_we, dm_rindex, dm_windex, dm_wdata,
    input  dm_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    output cpu_valid, cpu_op, cpu_addr, cpu_wdata, cpu_wstrb,
    input  cpu_ready, cpu_rdata,
    input  dm_we, dm_rindex, dm_windex, dm_wdata,
    output dm_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/dcache_tag_array.sv
// Tag/valid/dirty storage: asynchronously cleared, one combinational read port, one write port.
module dcache_tag_array
  import dcache_pkg::*;
(
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [INDEX_WIDTH-1:0] rd_idx,
  output tag_entry_t             rd_entry,
  input  logic                   we,
  input  logic [INDEX_WIDTH-1:0] wr_idx,
  input  tag_entry_t             wr_entry
);

  tag_entry_t entries [LINES];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < LINES; i++) entries[i] <= '0;
    end else if (we) begin
      entries[wr_idx] <= wr_entry;
    end
  end

  assign rd_entry = entries[rd_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back write-allocate data cache controller.
// Optional hit/miss counters are built in when DCACHE_STATS_EN is defined.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  dcache_if.master    bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] stat_hit,
  output logic [31:0] stat_miss
`endif
);

  state_t     state, state_nxt;
  cpu_req_t   req;
  logic       refilled;
  tag_entry_t entry;
  logic       tag_we;
  tag_entry_t tag_wr;
  logic       hit_c;

  logic [INDEX_WIDTH-1:0] idx;
  logic [TAG_W-1:0]       req_tag;
  logic [WSEL_W-1:0]      wsel;
  logic [1:0]             unused_addr_lsb;

  assign idx             = req.addr[OFF_W +: INDEX_WIDTH];
  assign req_tag         = req.addr[ADDR_WIDTH-1 -: TAG_W];
  assign wsel            = req.addr[OFF_W-1:2];
  assign unused_addr_lsb = req.addr[1:0];
  assign hit_c           = entry.valid && (entry.tag == req_tag);

  dcache_tag_array u_tags (
    .clk      (clk),
    .resetn   (resetn),
    .rd_idx   (idx),
    .rd_entry (entry),
    .we       (tag_we),
    .wr_idx   (idx),
    .wr_entry (tag_wr)
  );

  // State, captured request, and whether the current LOOKUP follows a refill.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      req      <= '0;
      refilled <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        refilled <= 1'b0;
        if (bus.cpu_valid) req <= '{op: bus.cpu_op, addr: bus.cpu_addr,
                                    wdata: bus.cpu_wdata, wstrb: bus.cpu_wstrb};
      end else if (state == REFILL && bus.mem_ack) begin
        refilled <= 1'b1;
      end
    end
  end

  // Read index looks ahead at the incoming address while idle.
  assign bus.dm_rindex = (state == IDLE) ? bus.cpu_addr[OFF_W +: INDEX_WIDTH] : idx;
  assign bus.dm_windex = idx;

  always_comb begin
    state_nxt     = state;
    bus.cpu_ready = 1'b0;
    bus.cpu_rdata = '0;
    bus.dm_we     = 1'b0;
    bus.dm_wdata  = '0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    tag_we        = 1'b0;
    tag_wr        = '0;
    case (state)
      IDLE: if (bus.cpu_valid) state_nxt = LOOKUP;
      LOOKUP: begin
        if (hit_c) begin
          bus.cpu_ready = 1'b1;
          state_nxt     = IDLE;
          if (req.op) begin
            bus.dm_we    = 1'b1;
            bus.dm_wdata = byte_merge(bus.dm_rdata, wsel, req.wdata, req.wstrb);
            tag_we       = 1'b1;
            tag_wr       = '{valid: 1'b1, dirty: 1'b1, tag: req_tag};
          end else begin
            bus.cpu_rdata = word_sel(bus.dm_rdata, wsel);
          end
        end else if (entry.valid && entry.dirty) begin
          state_nxt = WRITEBACK;
        end else begin
          state_nxt = REFILL;
        end
      end
      WRITEBACK: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = {entry.tag, idx, OFF_W'(0)};
        bus.mem_wdata = bus.dm_rdata;
        if (bus.mem_ack) state_nxt = REFILL;
      end
      REFILL: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = {req_tag, idx, OFF_W'(0)};
        if (bus.mem_ack) begin
          bus.dm_we    = 1'b1;
          bus.dm_wdata = bus.mem_rdata;
          tag_we       = 1'b1;
          tag_wr       = '{valid: 1'b1, dirty: 1'b0, tag: req_tag};
          state_nxt    = LOOKUP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef DCACHE_STATS_EN
  // Hits completed after a refill are not counted; the miss already was.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stat_hit  <= '0;
      stat_miss <= '0;
    end else if (state == LOOKUP) begin
      if (hit_c && !refilled) stat_hit <= stat_hit + 32'd1;
      if (!hit_c) stat_miss <= stat_miss + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl with a behavioural line data memory.
module tb_dcache_ctrl;
  import dcache_pkg::*;

  logic clk;
  logic resetn;
  int   tests;
  int   fails;

  dcache_if bus ();

`ifdef DCACHE_STATS_EN
  logic [31:0] stat_hit, stat_miss;
`endif

  dcache_ctrl dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
`ifdef DCACHE_STATS_EN
    ,
    .stat_hit  (stat_hit),
    .stat_miss (stat_miss)
`endif
  );

  logic [LINE_WIDTH-1:0] dmem [LINES];

  assign bus.dm_rdata = dmem[bus.dm_rindex];

  always @(posedge clk) begin
    if (bus.dm_we) dmem[bus.dm_windex] <= bus.dm_wdata;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [LINE_WIDTH-1:0] L1 = 128'hCAFE0003_CAFE0002_DEADBEEF_CAFE0000;
  localparam logic [LINE_WIDTH-1:0] M1 = 128'hCAFE0003_CAFE0002_DEAD3344_CAFE0000;
  localparam logic [LINE_WIDTH-1:0] L2 = 128'h12345678_9ABCDEF0_0BADF00D_0F0F0F0F;
  localparam logic [LINE_WIDTH-1:0] L3 = 128'h00000033_00000022_5555AAAA_00000000;

  task automatic chk(input string tag, input logic [LINE_WIDTH-1:0] obs,
                     input logic [LINE_WIDTH-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_req(input logic op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
    bus.cpu_valid = 1'b1;
    bus.cpu_op    = op;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    bus.cpu_wstrb = wstrb;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    for (int i = 0; i < int'(LINES); i++) dmem[i] = '0;
    bus.cpu_valid = 1'b0;
    bus.cpu_op    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.cpu_wstrb = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    resetn        = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_cpu_ready", 128'(bus.cpu_ready), 128'(0));
    chk("rst_cpu_rdata", 128'(bus.cpu_rdata), 128'(0));
    chk("rst_mem_req",   128'(bus.mem_req),   128'(0));
    chk("rst_dm_we",     128'(bus.dm_we),     128'(0));
    chk("rst_mem_addr",  128'(bus.mem_addr),  128'(0));
    resetn = 1'b1;

    // Cold read miss, refill, then completion one cycle after ack.
    @(negedge clk);
    cpu_req(1'b0, 32'h0000_1234, 32'h0, 4'h0);
    @(negedge clk);
    chk("cold_lookup_ready", 128'(bus.cpu_ready), 128'(0));
    chk("cold_lookup_req",   128'(bus.mem_req),   128'(0));
    @(negedge clk);
    chk("cold_refill_req",  128'(bus.mem_req),  128'(1));
    chk("cold_refill_we",   128'(bus.mem_we),   128'(0));
    chk("cold_refill_addr", 128'(bus.mem_addr), 128'(32'h0000_1230));
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = L1;
    #1;
    chk("cold_refill_dm_we",    128'(bus.dm_we), 128'(1));
    chk("cold_refill_dm_wdata", bus.dm_wdata,    L1);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("cold_done_ready", 128'(bus.cpu_ready), 128'(1));
    chk("cold_done_rdata", 128'(bus.cpu_rdata), 128'(32'hDEAD_BEEF));
    chk("cold_done_req",   128'(bus.mem_req),   128'(0));
    bus.cpu_valid = 1'b0;

    // Repeat read hits in T+1.
    @(negedge clk);
    cpu_req(1'b0, 32'h0000_1234, 32'h0, 4'h0);
    @(negedge clk);
    chk("hit_ready", 128'(bus.cpu_ready), 128'(1));
    chk("hit_rdata", 128'(bus.cpu_rdata), 128'(32'hDEAD_BEEF));
    chk("hit_req",   128'(bus.mem_req),   128'(0));
    bus.cpu_valid = 1'b0;

    // Partial write hit merges the low half-word.
    @(negedge clk);
    cpu_req(1'b1, 32'h0000_1234, 32'h1122_3344, 4'b0011);
    @(negedge clk);
    chk("wr_ready",    128'(bus.cpu_ready), 128'(1));
    chk("wr_dm_we",    128'(bus.dm_we),     128'(1));
    chk("wr_dm_wdata", bus.dm_wdata,        M1);
    chk("wr_req",      128'(bus.mem_req),   128'(0));
    bus.cpu_valid = 1'b0;

    // Conflicting tag: write back the dirty line, then refill.
    @(negedge clk);
    cpu_req(1'b0, 32'h0010_1234, 32'h0, 4'h0);
    @(negedge clk);
    chk("dirty_lookup_ready", 128'(bus.cpu_ready), 128'(0));
    @(negedge clk);
    chk("wb_req",   128'(bus.mem_req),  128'(1));
    chk("wb_we",    128'(bus.mem_we),   128'(1));
    chk("wb_addr",  128'(bus.mem_addr), 128'(32'h0000_1230));
    chk("wb_wdata", bus.mem_wdata,      M1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = L2;
    #1;
    chk("wb_ack_dm_we", 128'(bus.dm_we), 128'(0));
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("wb_refill_req",  128'(bus.mem_req),  128'(1));
    chk("wb_refill_we",   128'(bus.mem_we),   128'(0));
    chk("wb_refill_addr", 128'(bus.mem_addr), 128'(32'h0010_1230));
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("wb_done_ready", 128'(bus.cpu_ready), 128'(1));
    chk("wb_done_rdata", 128'(bus.cpu_rdata), 128'(32'h0BAD_F00D));
    bus.cpu_valid = 1'b0;
    @(negedge clk);
`ifdef DCACHE_STATS_EN
    chk("stat_hit",  128'(stat_hit),  128'(2));
    chk("stat_miss", 128'(stat_miss), 128'(2));
`endif

    // Ack while idle must not start anything.
    bus.mem_ack = 1'b1;
    #1;
    chk("idle_ack_req",   128'(bus.mem_req), 128'(0));
    chk("idle_ack_dm_we", 128'(bus.dm_we),   128'(0));
    @(negedge clk);
    bus.mem_ack = 1'b0;

    // Reset in the middle of a refill; valid bits must be gone afterwards.
    cpu_req(1'b0, 32'h0000_1234, 32'h0, 4'h0);
    repeat (2) @(negedge clk);
    chk("pre_rst_req",  128'(bus.mem_req),  128'(1));
    chk("pre_rst_addr", 128'(bus.mem_addr), 128'(32'h0000_1230));
    #1 resetn = 1'b0;
    #1;
    chk("mid_rst_req", 128'(bus.mem_req), 128'(0));
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_lookup_ready", 128'(bus.cpu_ready), 128'(0));
    @(negedge clk);
    chk("post_rst_req",  128'(bus.mem_req),  128'(1));
    chk("post_rst_we",   128'(bus.mem_we),   128'(0));
    chk("post_rst_addr", 128'(bus.mem_addr), 128'(32'h0000_1230));
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = L3;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("post_rst_ready", 128'(bus.cpu_ready), 128'(1));
    chk("post_rst_rdata", 128'(bus.cpu_rdata), 128'(32'h5555_AAAA));
    bus.cpu_valid = 1'b0;

    // The line held before reset was cleared, so its old tag misses cleanly.
    @(negedge clk);
    cpu_req(1'b0, 32'h0010_1234, 32'h0, 4'h0);
    @(negedge clk);
    chk("old_tag_ready", 128'(bus.cpu_ready), 128'(0));
    @(negedge clk);
    chk("old_tag_we",   128'(bus.mem_we),   128'(0));
    chk("old_tag_addr", 128'(bus.mem_addr), 128'(32'h0010_1230));
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = L2;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("old_tag_done", 128'(bus.cpu_rdata), 128'(32'h0BAD_F00D));
    bus.cpu_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
